word_match_engine: RTL and testbench

//  Parametrised hangman word store and guess matcher. Captures a secret word one char/cycle, then scans it per guess.

---
 rtl/hangman_pkg.sv | 20 ++
 rtl/word_store.sv | 53 +++++
 rtl/word_match_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_word_match_engine.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// hangman_pkg: shared definitions for the hangman word matcher.
//   state_e          - controller states of word_match_engine
//   *_DEF constants  - default CHAR_W / MAX_LEN / MAX_MISSES values
package hangman_pkg;

    localparam int CHAR_W_DEF     = 5;
    localparam int MAX_LEN_DEF    = 16;
    localparam int MAX_MISSES_DEF = 6;

    typedef enum logic [2:0] {
        S_LOAD,
        S_WAIT,
        S_SCAN,
        S_EMIT,
        S_RESULT,
        S_WON,
        S_LOST
    } state_e;

endpackage

// File: rtl/word_store.sv
// word_store: MAX_LEN x CHAR_W character registers plus one reveal bit
// per position.
// Ports:
//   clk_i          clock (posedge)
//   clr_i          synchronous clear of chars and reveal bits
//   wr_en_i        write wr_data_i at wr_addr_i
//   wr_addr_i      write index
//   wr_data_i      character to write
//   rd_addr_i      read index; also the position marked by rev_set_i
//   rev_set_i      set the reveal bit at rd_addr_i
//   rd_data_o      character at rd_addr_i (combinational)
//   rd_revealed_o  reveal bit at rd_addr_i (combinational)
module word_store
    import hangman_pkg::*;
#(
    parameter  int CHAR_W  = CHAR_W_DEF,
    parameter  int MAX_LEN = MAX_LEN_DEF,
    localparam int ADDR_W  = $clog2(MAX_LEN)
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [CHAR_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rev_set_i,
    output logic [CHAR_W-1:0] rd_data_o,
    output logic              rd_revealed_o
);

    logic [CHAR_W-1:0]  mem_q [MAX_LEN];
    logic [MAX_LEN-1:0] rev_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            mem_q <= '{default: '0};
            rev_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
            // Reveal uses the scan (read) index: a position is only ever
            // revealed while it is the one being compared.
            if (rev_set_i) begin
                rev_q[rd_addr_i] <= 1'b1;
            end
        end
    end

    assign rd_data_o     = mem_q[rd_addr_i];
    assign rd_revealed_o = rev_q[rd_addr_i];

endmodule

// File: rtl/word_match_engine.sv
// word_match_engine: hangman secret-word store and guess matcher.
// Loads a word one char per cycle, then scans it once per accepted guess,
// streaming each newly revealed position over a valid/ready handshake and
// tracking misses, unrevealed count and win/lose.
// Optional feature macro: REPEAT_FILTER_EN (guessed-letter map; repeated
// guesses skip the scan, do not miss, and raise result_repeat).
// Ports:
//   clk, resetn (sync, active-high), new_game (pulse, restart in LOAD)
//   ld_valid/ld_char/ld_done       word load interface (LOAD only)
//   guess_valid/guess_char/guess_ready   guess handshake (ready in WAIT)
//   hit_valid/hit_ready/hit_pos/hit_char newly revealed position stream
//   result_valid/result_hit[/result_repeat] end-of-guess pulse
//   miss_count, remain, word_len   counters
//   won, lost, overflow            sticky status
module word_match_engine
    import hangman_pkg::*;
#(
    parameter  int CHAR_W     = CHAR_W_DEF,
    parameter  int MAX_LEN    = MAX_LEN_DEF,
    parameter  int MAX_MISSES = MAX_MISSES_DEF,
    localparam int ADDR_W     = $clog2(MAX_LEN),
    localparam int MISS_W     = $clog2(MAX_MISSES + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              new_game,
    input  logic              ld_valid,
    input  logic [CHAR_W-1:0] ld_char,
    input  logic              ld_done,
    input  logic              guess_valid,
    input  logic [CHAR_W-1:0] guess_char,
    output logic              guess_ready,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic [ADDR_W-1:0] hit_pos,
    output logic [CHAR_W-1:0] hit_char,
    output logic              result_valid,
    output logic              result_hit,
`ifdef REPEAT_FILTER_EN
    output logic              result_repeat,
`endif
    output logic [MISS_W-1:0] miss_count,
    output logic [ADDR_W:0]   remain,
    output logic [ADDR_W:0]   word_len,
    output logic              won,
    output logic              lost,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISSES);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   word_len_q, word_len_d, len_after;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CHAR_W-1:0] guess_q, guess_d;
    logic              hit_flag_q, hit_flag_d;
    logic [ADDR_W-1:0] hit_pos_q, hit_pos_d;
    logic [CHAR_W-1:0] hit_char_q, hit_char_d;
    logic              overflow_q, overflow_d;
    logic              last_idx;

    logic              st_clr, st_wr_en, st_rev_set;
    logic [CHAR_W-1:0] st_rd_data;
    logic              st_rd_rev;

`ifdef REPEAT_FILTER_EN
    logic [2**CHAR_W-1:0] map_q, map_d;
    logic                 repeat_q, repeat_d;
`endif

    word_store #(
        .CHAR_W  (CHAR_W),
        .MAX_LEN (MAX_LEN)
    ) u_store (
        .clk_i         (clk),
        .clr_i         (st_clr),
        .wr_en_i       (st_wr_en),
        .wr_addr_i     (word_len_q[ADDR_W-1:0]),
        .wr_data_i     (ld_char),
        .rd_addr_i     (idx_q),
        .rev_set_i     (st_rev_set),
        .rd_data_o     (st_rd_data),
        .rd_revealed_o (st_rd_rev)
    );

    assign last_idx = ({1'b0, idx_q} == (word_len_q - 1'b1));

    always_comb begin
        state_d    = state_q;
        word_len_d = word_len_q;
        len_after  = word_len_q;
        remain_d   = remain_q;
        miss_d     = miss_q;
        idx_d      = idx_q;
        guess_d    = guess_q;
        hit_flag_d = hit_flag_q;
        hit_pos_d  = hit_pos_q;
        hit_char_d = hit_char_q;
        overflow_d = overflow_q;
        st_clr     = resetn;
        st_wr_en   = 1'b0;
        st_rev_set = 1'b0;
`ifdef REPEAT_FILTER_EN
        map_d      = map_q;
        repeat_d   = repeat_q;
`endif

        unique case (state_q)
            S_LOAD: begin
                if (ld_valid) begin
                    if (word_len_q == LEN_MAX) begin
                        overflow_d = 1'b1;
                    end else begin
                        st_wr_en  = 1'b1;
                        len_after = word_len_q + 1'b1;
                    end
                end
                word_len_d = len_after;
                // Commit sees the length including a same-cycle store.
                if (ld_done && (len_after != '0)) begin
                    remain_d = len_after;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (guess_valid) begin
                    guess_d    = guess_char;
                    idx_d      = '0;
                    hit_flag_d = 1'b0;
                    state_d    = S_SCAN;
`ifdef REPEAT_FILTER_EN
                    repeat_d              = map_q[guess_char];
                    map_d[guess_char]     = 1'b1;
                    if (map_q[guess_char]) begin
                        state_d = S_RESULT;
                    end
`endif
                end
            end
            S_SCAN: begin
                if ((st_rd_data == guess_q) && !st_rd_rev) begin
                    st_rev_set = 1'b1;
                    remain_d   = remain_q - 1'b1;
                    hit_flag_d = 1'b1;
                    hit_pos_d  = idx_q;
                    hit_char_d = st_rd_data;
                    state_d    = S_EMIT;
                end else if (last_idx) begin
                    state_d = S_RESULT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (hit_ready) begin
                    if (last_idx) begin
                        state_d = S_RESULT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SCAN;
                    end
                end
            end
            S_RESULT: begin
                if (!hit_flag_q
`ifdef REPEAT_FILTER_EN
                    && !repeat_q
`endif
                    && (miss_q != MISS_MAX)) begin
                    miss_d = miss_q + 1'b1;
                end
                if (remain_q == '0) begin
                    state_d = S_WON;
                end else if (miss_d == MISS_MAX) begin
                    state_d = S_LOST;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: ;
        endcase

        if (new_game) begin
            state_d    = S_LOAD;
            word_len_d = '0;
            remain_d   = '0;
            miss_d     = '0;
            idx_d      = '0;
            guess_d    = '0;
            hit_flag_d = 1'b0;
            hit_pos_d  = '0;
            hit_char_d = '0;
            overflow_d = 1'b0;
            st_clr     = 1'b1;
            st_wr_en   = 1'b0;
            st_rev_set = 1'b0;
`ifdef REPEAT_FILTER_EN
            map_d      = '0;
            repeat_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q    <= S_LOAD;
            word_len_q <= '0;
            remain_q   <= '0;
            miss_q     <= '0;
            idx_q      <= '0;
            guess_q    <= '0;
            hit_flag_q <= 1'b0;
            hit_pos_q  <= '0;
            hit_char_q <= '0;
            overflow_q <= 1'b0;
`ifdef REPEAT_FILTER_EN
            map_q      <= '0;
            repeat_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_len_q <= word_len_d;
            remain_q   <= remain_d;
            miss_q     <= miss_d;
            idx_q      <= idx_d;
            guess_q    <= guess_d;
            hit_flag_q <= hit_flag_d;
            hit_pos_q  <= hit_pos_d;
            hit_char_q <= hit_char_d;
            overflow_q <= overflow_d;
`ifdef REPEAT_FILTER_EN
            map_q      <= map_d;
            repeat_q   <= repeat_d;
`endif
        end
    end

    assign guess_ready  = (state_q == S_WAIT);
    assign hit_valid    = (state_q == S_EMIT);
    assign hit_pos      = hit_pos_q;
    assign hit_char     = hit_char_q;
    assign result_valid = (state_q == S_RESULT);
    assign result_hit   = (state_q == S_RESULT) && hit_flag_q;
`ifdef REPEAT_FILTER_EN
    assign result_repeat = (state_q == S_RESULT) && repeat_q;
`endif
    assign miss_count   = miss_q;
    assign remain       = remain_q;
    assign word_len     = word_len_q;
    assign won          = (state_q == S_WON);
    assign lost         = (state_q == S_LOST);
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_word_match_engine.sv
module tb_word_match_engine;

    localparam int CHAR_W     = 5;
    localparam int MAX_LEN    = 16;
    localparam int MAX_MISSES = 6;
    localparam int ADDR_W     = $clog2(MAX_LEN);
    localparam int MISS_W     = $clog2(MAX_MISSES + 1);

    logic              clk = 1'b0;
    logic              resetn, new_game, ld_valid, ld_done, guess_valid, hit_ready;
    logic [CHAR_W-1:0] ld_char, guess_char;
    logic              guess_ready, hit_valid, result_valid, result_hit;
    logic [ADDR_W-1:0] hit_pos;
    logic [CHAR_W-1:0] hit_char;
    logic [MISS_W-1:0] miss_count;
    logic [ADDR_W:0]   remain, word_len;
    logic              won, lost, overflow;
    logic              result_repeat;

    always #5 clk = ~clk;

    word_match_engine #(
        .CHAR_W     (CHAR_W),
        .MAX_LEN    (MAX_LEN),
        .MAX_MISSES (MAX_MISSES)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .new_game     (new_game),
        .ld_valid     (ld_valid),
        .ld_char      (ld_char),
        .ld_done      (ld_done),
        .guess_valid  (guess_valid),
        .guess_char   (guess_char),
        .guess_ready  (guess_ready),
        .hit_valid    (hit_valid),
        .hit_ready    (hit_ready),
        .hit_pos      (hit_pos),
        .hit_char     (hit_char),
        .result_valid (result_valid),
        .result_hit   (result_hit),
`ifdef REPEAT_FILTER_EN
        .result_repeat(result_repeat),
`endif
        .miss_count   (miss_count),
        .remain       (remain),
        .word_len     (word_len),
        .won          (won),
        .lost         (lost),
        .overflow     (overflow)
    );

`ifndef REPEAT_FILTER_EN
    assign result_repeat = 1'b0;
`endif

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    // Reference model: the word as a plain array, revealed positions,
    // counters and game result, updated by the rules of the game.
    int m_word [MAX_LEN];
    bit m_rev  [MAX_LEN];
    bit m_guessed [2**CHAR_W];
    int m_len, m_remain, m_miss;
    bit m_won, m_lost;
    int exp_pos[$];
    bit exp_repeat;
    int w_in [20];

    // Observations of one guess transaction.
    int obs_pos[$];
    int obs_char[$];
    bit obs_res_hit, obs_res_rep, obs_stable, obs_timeout;
    int obs_cycle;

    function automatic void model_new();
        for (int i = 0; i < MAX_LEN; i++) begin m_word[i] = 0; m_rev[i] = 0; end
        for (int i = 0; i < 2**CHAR_W; i++) m_guessed[i] = 0;
        m_len = 0; m_remain = 0; m_miss = 0; m_won = 0; m_lost = 0;
    endfunction

    function automatic void model_guess(input int g);
        exp_pos.delete();
        exp_repeat = 0;
`ifdef REPEAT_FILTER_EN
        if (m_guessed[g]) begin
            exp_repeat = 1;
            return;
        end
        m_guessed[g] = 1;
`endif
        for (int i = 0; i < m_len; i++) begin
            if (m_word[i] == g && !m_rev[i]) begin
                m_rev[i] = 1;
                exp_pos.push_back(i);
                m_remain--;
            end
        end
        if (exp_pos.size() == 0 && m_miss < MAX_MISSES) m_miss++;
        if (m_remain == 0) m_won = 1;
        else if (m_miss == MAX_MISSES) m_lost = 1;
    endfunction

    task automatic do_reset();
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        model_new();
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_new();
    endtask

    // Loads w_in[0..len-1]; combine puts ld_done on the last char's cycle.
    task automatic load_word(input int len, input bit combine);
        for (int i = 0; i < len; i++) begin
            ld_valid = 1'b1;
            ld_char  = w_in[i][CHAR_W-1:0];
            ld_done  = combine && (i == len - 1);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        if (!combine) begin
            ld_done = 1'b1;
            @(negedge clk);
        end
        ld_done = 1'b0;
        m_len = (len > MAX_LEN) ? MAX_LEN : len;
        for (int i = 0; i < m_len; i++) m_word[i] = w_in[i];
        m_remain = m_len;
    endtask

    // Offers one guess (engine must be in WAIT), holds hit_ready low for
    // 'stall' cycles of every hit, returns after the post-result edge.
    task automatic do_guess(input int g, input int stall);
        int stall_left;
        int held_pos, held_char;
        obs_pos.delete(); obs_char.delete();
        obs_res_hit = 0; obs_res_rep = 0; obs_stable = 1; obs_timeout = 1; obs_cycle = 0;
        guess_valid = 1'b1;
        guess_char  = g[CHAR_W-1:0];
        @(negedge clk);
        guess_valid = 1'b0;
        stall_left = stall;
        held_pos = -1; held_char = -1;
        for (int c = 1; c <= 200; c++) begin
            if (hit_valid) begin
                if (held_pos >= 0 && (int'(hit_pos) != held_pos || int'(hit_char) != held_char))
                    obs_stable = 0;
                held_pos = int'(hit_pos);
                held_char = int'(hit_char);
                if (stall_left > 0) begin
                    stall_left--;
                    hit_ready = 1'b0;
                end else begin
                    hit_ready = 1'b1;
                    obs_pos.push_back(int'(hit_pos));
                    obs_char.push_back(int'(hit_char));
                    held_pos = -1;
                    stall_left = stall;
                end
            end else begin
                hit_ready = 1'b0;
            end
            if (result_valid) begin
                obs_res_hit = result_hit;
                obs_res_rep = result_repeat;
                obs_cycle   = c;
                obs_timeout = 0;
                break;
            end
            @(negedge clk);
        end
        hit_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({guess_ready, hit_valid, hit_pos, hit_char, result_valid, result_hit,
             miss_count, remain, word_len, won, lost, overflow} !== '0)
            $display("FAIL reset_outputs: got ready=%b hv=%b rv=%b miss=%0d remain=%0d len=%0d won=%b lost=%b ovf=%b, want all 0",
                     guess_ready, hit_valid, result_valid, miss_count, remain, word_len, won, lost, overflow);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        pulse_new_game();
        w_in[0] = 3; w_in[1] = 1; w_in[2] = 20;
        load_word(3, 0);
        total_cnt++;
        if (word_len !== 5'd3 || guess_ready !== 1'b1 || remain !== 5'd3)
            $display("FAIL basic_commit: got len=%0d ready=%b remain=%0d, want 3 1 3", word_len, guess_ready, remain);
        else pass_cnt++;
        model_guess(1);
        do_guess(1, 0);
        total_cnt++;
        if (obs_pos.size() != 1 || obs_pos[0] != 1 || obs_char[0] != 1)
            $display("FAIL basic_hit: got %0d hits first=%0d, want 1 hit pos=1 char=1", obs_pos.size(),
                     (obs_pos.size() > 0) ? obs_pos[0] : -1);
        else pass_cnt++;
        total_cnt++;
        if (obs_res_hit !== 1'b1 || obs_cycle != 5)
            $display("FAIL basic_result: got hit=%b cycle=%0d, want 1 5", obs_res_hit, obs_cycle);
        else pass_cnt++;
        total_cnt++;
        if (remain !== 5'd2 || miss_count !== 3'd0)
            $display("FAIL basic_counts: got remain=%0d miss=%0d, want 2 0", remain, miss_count);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        pulse_new_game();
        w_in[0] = 2; w_in[1] = 2; w_in[2] = 5;
        load_word(3, 0);
        model_guess(2);
        do_guess(2, 3);
        total_cnt++;
        if (obs_pos.size() != 2 || obs_pos[0] != 0 || obs_pos[1] != 1 || obs_char[0] != 2 || obs_char[1] != 2)
            $display("FAIL stall_hits: got %0d hits, want pos0,pos1 char 2", obs_pos.size());
        else pass_cnt++;
        total_cnt++;
        if (obs_stable !== 1'b1 || obs_cycle != 12)
            $display("FAIL stall_hold: got stable=%b cycle=%0d, want 1 12", obs_stable, obs_cycle);
        else pass_cnt++;
        model_guess(5);
        do_guess(5, 0);
        total_cnt++;
        if (remain !== 5'd0 || won !== 1'b1 || guess_ready !== 1'b0 || lost !== 1'b0)
            $display("FAIL stall_win: got remain=%0d won=%b ready=%b lost=%b, want 0 1 0 0", remain, won, guess_ready, lost);
        else pass_cnt++;
    endtask

    task automatic test_lose();
        int seen;
        pulse_new_game();
        w_in[0] = 1; w_in[1] = 2; w_in[2] = 3; w_in[3] = 4;
        load_word(4, 0);
        for (int k = 1; k <= MAX_MISSES; k++) begin
            model_guess(9 + k);
            do_guess(9 + k, 0);
            total_cnt++;
            if (miss_count !== MISS_W'(k) || obs_res_hit !== 1'b0 || obs_cycle != 5)
                $display("FAIL lose_miss%0d: got miss=%0d hit=%b cycle=%0d, want %0d 0 5", k, miss_count, obs_res_hit, obs_cycle, k);
            else pass_cnt++;
            total_cnt++;
            if (lost !== (k == MAX_MISSES))
                $display("FAIL lose_flag%0d: got lost=%b want %b", k, lost, (k == MAX_MISSES));
            else pass_cnt++;
        end
        seen = 0;
        guess_valid = 1'b1;
        guess_char  = 5'd1;
        for (int c = 0; c < 6; c++) begin
            if (guess_ready || result_valid) seen++;
            @(negedge clk);
        end
        guess_valid = 1'b0;
        total_cnt++;
        if (seen != 0 || miss_count !== 3'd6 || lost !== 1'b1)
            $display("FAIL lose_ignore: got %0d ready/result cycles miss=%0d lost=%b, want 0 6 1", seen, miss_count, lost);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        pulse_new_game();
        ld_done = 1'b1;
        @(negedge clk);
        ld_done = 1'b0;
        total_cnt++;
        if (guess_ready !== 1'b0 || word_len !== 5'd0)
            $display("FAIL empty_commit: got ready=%b len=%0d, want 0 0", guess_ready, word_len);
        else pass_cnt++;
        for (int i = 0; i < 17; i++) w_in[i] = i;
        load_word(17, 0);
        total_cnt++;
        if (word_len !== 5'd16 || overflow !== 1'b1 || remain !== 5'd16)
            $display("FAIL overflow: got len=%0d ovf=%b remain=%0d, want 16 1 16", word_len, overflow, remain);
        else pass_cnt++;
        pulse_new_game();
        w_in[0] = 7; w_in[1] = 8; w_in[2] = 9;
        load_word(3, 1);
        total_cnt++;
        if (word_len !== 5'd3 || guess_ready !== 1'b1 || remain !== 5'd3 || overflow !== 1'b0)
            $display("FAIL combined_commit: got len=%0d ready=%b remain=%0d ovf=%b, want 3 1 3 0", word_len, guess_ready, remain, overflow);
        else pass_cnt++;
        model_guess(9);
        do_guess(9, 0);
        total_cnt++;
        if (obs_pos.size() != 1 || obs_pos[0] != 2 || obs_char[0] != 9)
            $display("FAIL combined_last_char: got %0d hits, want pos 2 char 9", obs_pos.size());
        else pass_cnt++;
    endtask

    task automatic test_midreset();
        bit seen;
        pulse_new_game();
        w_in[0] = 3; w_in[1] = 1; w_in[2] = 20;
        load_word(3, 0);
        hit_ready   = 1'b0;
        guess_valid = 1'b1;
        guess_char  = 5'd1;
        @(negedge clk);
        guess_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (hit_valid) seen = 1;
            else @(negedge clk);
        end
        total_cnt++;
        if (seen !== 1'b1) $display("FAIL emit_reached: got hit_valid never, want 1");
        else pass_cnt++;
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        model_new();
        total_cnt++;
        if ({guess_ready, hit_valid, hit_pos, hit_char, result_valid, result_hit,
             miss_count, remain, word_len, won, lost, overflow} !== '0)
            $display("FAIL reset_mid_emit: got hv=%b pos=%0d char=%0d remain=%0d len=%0d, want all 0",
                     hit_valid, hit_pos, hit_char, remain, word_len);
        else pass_cnt++;
        load_word(3, 0);
        pulse_new_game();
        total_cnt++;
        if ({guess_ready, hit_valid, hit_pos, hit_char, result_valid, result_hit,
             miss_count, remain, word_len, won, lost, overflow} !== '0)
            $display("FAIL new_game_wait: got ready=%b remain=%0d len=%0d, want all 0", guess_ready, remain, word_len);
        else pass_cnt++;
    endtask

    task automatic test_repeat();
        int exp_cycle;
        pulse_new_game();
        w_in[0] = 3; w_in[1] = 1; w_in[2] = 20;
        load_word(3, 0);
        model_guess(1);
        do_guess(1, 0);
        model_guess(1);
        do_guess(1, 0);
        exp_cycle = exp_repeat ? 1 : 4;
        total_cnt++;
        if (obs_res_hit !== 1'b0 || obs_pos.size() != 0 || obs_res_rep !== exp_repeat || obs_cycle != exp_cycle)
            $display("FAIL repeat_result: got hit=%b hits=%0d rep=%b cycle=%0d, want 0 0 %b %0d",
                     obs_res_hit, obs_pos.size(), obs_res_rep, obs_cycle, exp_repeat, exp_cycle);
        else pass_cnt++;
        total_cnt++;
        if (miss_count !== MISS_W'(m_miss) || remain !== 5'd2)
            $display("FAIL repeat_miss: got miss=%0d remain=%0d, want %0d 2", miss_count, remain, m_miss);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int len, g, stall, exp_cycle;
        bit ok;
        for (int game = 0; game < 12; game++) begin
            pulse_new_game();
            len = $urandom_range(2, 10);
            for (int i = 0; i < len; i++) w_in[i] = $urandom_range(0, 5);
            load_word(len, $urandom_range(0, 1) == 1);
            for (int n = 0; n < 30 && !m_won && !m_lost; n++) begin
                g = $urandom_range(0, 7);
                stall = $urandom_range(0, 2);
                model_guess(g);
                exp_cycle = exp_repeat ? 1 : m_len + 1 + exp_pos.size() * (stall + 1);
                do_guess(g, stall);
                ok = (obs_pos.size() == exp_pos.size());
                for (int i = 0; ok && i < exp_pos.size(); i++)
                    if (obs_pos[i] != exp_pos[i] || obs_char[i] != m_word[exp_pos[i]]) ok = 0;
                total_cnt++;
                if (!ok || obs_stable !== 1'b1)
                    $display("FAIL rand_hits g%0d guess=%0d: got %0d hits stable=%b, want %0d", game, g,
                             obs_pos.size(), obs_stable, exp_pos.size());
                else pass_cnt++;
                total_cnt++;
                if (obs_timeout || obs_cycle != exp_cycle || obs_res_hit !== (exp_pos.size() > 0) || obs_res_rep !== exp_repeat)
                    $display("FAIL rand_result g%0d guess=%0d: got cycle=%0d hit=%b rep=%b, want %0d %b %b", game, g,
                             obs_cycle, obs_res_hit, obs_res_rep, exp_cycle, (exp_pos.size() > 0), exp_repeat);
                else pass_cnt++;
                total_cnt++;
                if (miss_count !== MISS_W'(m_miss) || remain !== (ADDR_W+1)'(m_remain) || won !== m_won || lost !== m_lost)
                    $display("FAIL rand_state g%0d: got miss=%0d remain=%0d won=%b lost=%b, want %0d %0d %b %b", game,
                             miss_count, remain, won, lost, m_miss, m_remain, m_won, m_lost);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        resetn = 1'b1; new_game = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;
        ld_char = '0; guess_valid = 1'b0; guess_char = '0; hit_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_lose();
        test_overflow();
        test_midreset();
        test_repeat();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
